// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_transmitter among NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to build the tx_done watchdog (err_timeout pulse on expiry).
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy,
    output logic                       tx_req,
    output logic [7:0]                 tx_din,
    input  logic                       tx_done,
    output logic                       err_timeout
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

    state_t            state_q;
    logic [IW-1:0]     ptr_q, grant_q, sel_d, ptr_d;
    logic [NUM_REQ-1:0] ack_q;
    logic              busy_q, tx_req_q;
    logic [7:0]        din_q;

    // Highest offset first so the requester closest to ptr wins.
    always_comb begin
        sel_d = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % NUM_REQ]) sel_d = IW'((int'(ptr_q) + i) % NUM_REQ);
        end
    end

    assign ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            tx_req_q <= 1'b0;
            din_q    <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ack_q    <= '0;
            tx_req_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: if (|req) begin
                    grant_q  <= sel_d;
                    din_q    <= req_data[8*sel_d +: 8];
                    busy_q   <= 1'b1;
                    tx_req_q <= 1'b1;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= ACK;
`ifdef UART_ARB_TIMEOUT_EN
                    // Expire on the cycle the count would reach TIMEOUT_CYCLES-1.
                    end else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;
    assign tx_req    = tx_req_q;
    assign tx_din    = din_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, handshake timing, withdrawal and reset.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  grant_idx;
    logic        busy, tx_req, tx_done, err_timeout;
    logic [7:0]  tx_din;
    int          tests = 0;
    int          fails = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .grant_idx(grant_idx), .busy(busy), .tx_req(tx_req), .tx_din(tx_din),
        .tx_done(tx_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_grant"}, 32'(grant_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_txreq"}, 32'(tx_req), 0);
        chk({tag, "_din"}, 32'(tx_din), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    // One full frame from an idle arbiter: grant, issue, wait, tx_done, ack, back to idle.
    task automatic frame(input int g, input logic [7:0] din, input int wait_n,
                         input bit withdraw, input bit drop);
        tick();
        chk("grant_txreq", 32'(tx_req), 1);
        chk("grant_idx", 32'(grant_idx), 32'(g));
        chk("grant_din", 32'(tx_din), 32'(din));
        chk("grant_busy", 32'(busy), 1);
        chk("grant_ack", 32'(ack), 0);
        tick();
        chk("wait_txreq", 32'(tx_req), 0);
        if (withdraw) begin
            req[g] = 1'b0;
            req_data[8*g +: 8] = 8'hFF;
        end
        repeat (wait_n) tick();
        chk("wait_din", 32'(tx_din), 32'(din));
        chk("wait_grant", 32'(grant_idx), 32'(g));
        chk("wait_ack", 32'(ack), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("ack", 32'(ack), 32'(1) << g);
        chk("ack_txreq", 32'(tx_req), 0);
        chk("ack_busy", 32'(busy), 1);
        if (drop) req[g] = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ack", 32'(ack), 0);
        chk("idle_err", 32'(err_timeout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        chk_reset_vals("idle_noreq");

        req = 4'b0001; req_data[7:0] = 8'hA5;
        frame(0, 8'hA5, 19, 1'b0, 1'b1);

        req = 4'b1010; req_data[15:8] = 8'h11; req_data[31:24] = 8'h33;
        frame(1, 8'h11, 3, 1'b0, 1'b1);
        frame(3, 8'h33, 3, 1'b0, 1'b1);

        req = 4'b1111; req_data = 32'h44_5C_22_66;
        for (int k = 0; k < 8; k++) begin
            case (k % 4)
                0: frame(0, 8'h66, 2, 1'b0, 1'b0);
                1: frame(1, 8'h22, 2, 1'b0, 1'b0);
                2: frame(2, 8'h5C, 2, 1'b0, 1'b0);
                default: frame(3, 8'h44, 2, 1'b0, 1'b0);
            endcase
        end
        req = '0;
        tick();
        chk("rr_quiet_busy", 32'(busy), 0);

        req = 4'b0100; req_data[23:16] = 8'h5C;
        frame(2, 8'h5C, 4, 1'b1, 1'b0);
        chk("withdraw_req_gone", 32'(req), 0);

        req = 4'b0001; req_data[7:0] = 8'h42;
        tick(); tick(); tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1; tx_done = 1'b1;
        tick();
        rst = 1'b0; tx_done = 1'b0;
        chk_reset_vals("mid_rst");
        frame(0, 8'h42, 3, 1'b0, 1'b1);

`ifdef UART_ARB_TIMEOUT_EN
        req = 4'b0011; req_data[15:8] = 8'h11;
        tick();
        chk("to_grant", 32'(grant_idx), 1);
        chk("to_txreq", 32'(tx_req), 1);
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k < 50) chk("to_err_early", 32'(err_timeout), 0);
        end
        chk("to_err", 32'(err_timeout), 1);
        chk("to_ack", 32'(ack), 0);
        chk("to_busy", 32'(busy), 0);
        tick();
        chk("to_err_once", 32'(err_timeout), 0);
        chk("to_next_grant", 32'(grant_idx), 0);
        chk("to_next_txreq", 32'(tx_req), 1);
        req = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_transmitter among NUM_REQ byte producers.
- Sits between the requesters and the transmitter's tx_req/din/tx_done handshake, in the same clock domain as uart_top.
- Sequences one complete byte frame at a time and returns a per-requester completion pulse.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 2_000_000: clock cycles allowed from issue to tx_done. Used only with UART_ARB_TIMEOUT_EN. Default covers one 9600-baud frame at 100 MHz, with margin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester. Must be held until the matching ack.
- req_data  in  8*NUM_REQ  byte per requester. Requester k uses bits [8k+7:8k].
- ack  out  NUM_REQ  one-cycle pulse to requester k when its byte has finished transmitting.
- grant_idx  out  clog2(NUM_REQ)  index of the requester currently being served.
- busy  out  1  high from grant until ack, inclusive.
- tx_req  out  1  start pulse to uart_transmitter.
- tx_din  out  8  byte to uart_transmitter.
- tx_done  in  1  one-cycle completion pulse from uart_transmitter.
- err_timeout  out  1  one-cycle pulse on watchdog abort. Tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset values:
  - ack=0, grant_idx=0, busy=0, tx_req=0, tx_din=8'h00, err_timeout=0.
  - FSM=IDLE, round-robin pointer ptr=0.
  - Reset has the same effect mid-frame; no ack is issued for the aborted byte.
- FSM states: IDLE, ISSUE, WAIT_DONE, ACK.
- IDLE:
  - If any req bit is set, select the first set bit scanning ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - Register grant_idx. Latch that requester's byte into tx_din. Set busy=1. Go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - tx_req=1 for exactly this one cycle. Go to WAIT_DONE.
- WAIT_DONE:
  - tx_req=0. tx_din and grant_idx are held stable.
  - On tx_done=1, go to ACK.
  - A tx_done seen in any other state is ignored.
- ACK:
  - ack[grant_idx]=1 for this one cycle.
  - ptr <= grant_idx+1, wrapping to 0 after NUM_REQ-1.
  - busy drops to 0 on the next cycle. Go to IDLE.
- Latency, for an idle arbiter with req asserted at cycle 0:
  - grant at cycle 1 edge.
  - tx_req high during cycle 1.
  - ack high the cycle after the tx_done pulse.
- Back-to-back: a requester still holding req in the cycle after its ack is treated as a new request. Its priority is lowest because ptr has already advanced.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- Request withdrawn:
  - Withdrawal after grant has no effect. The latched byte is still sent and acked.
  - Changes to req_data after grant are ignored.
- Simultaneous events:
  - New req bits arriving during a frame are not sampled until IDLE.
  - tx_done coinciding with rst: rst wins.
- Only one ack bit is ever set at a time. ack and tx_req are never high in the same cycle.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears in ISSUE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done: pulse err_timeout for one cycle, suppress ack, set ptr <= grant_idx+1, clear busy, return to IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES).
  - tx_done arriving on the same cycle as expiry takes priority: a normal ACK, no error.
- When undefined: no counter is built, err_timeout is constant 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Reset, then req=4'b0001 with req_data[7:0]=8'hA5, tx_done pulsed 20 cycles after tx_req:
  - tx_req is a single-cycle pulse with tx_din=8'hA5.
  - grant_idx=0, busy=1.
  - ack=4'b0001 one cycle after tx_done, busy=0 on the following cycle.
- req=4'b1010 asserted together and held, bytes 8'h11 (req 1) and 8'h33 (req 3):
  - Frames are sent as 8'h11 then 8'h33, with acks 4'b0010 then 4'b1000.
  - ptr ends at 0.
- req=4'b1111 held for 8 frames:
  - grant order is 0,1,2,3,0,1,2,3.
  - tx_din changes only at grant.
  - no ack overlaps tx_req.
- Requester 2 drops req and changes req_data to 8'hFF during WAIT_DONE:
  - tx_din stays at the original 8'h5C.
  - ack[2] still pulses.
- rst asserted mid-WAIT_DONE with req=4'b0001:
  - Next cycle all outputs are at reset values and no ack is issued.
  - After rst is released, a fresh grant to requester 0 issues tx_req again.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, no tx_done returned:
  - err_timeout pulses once 50 cycles after ISSUE.
  - No ack; the arbiter returns to IDLE and grants the next pending requester.
